// File: rtl/ntt_pkg.sv
// Shared types and index helpers for the NTT stage reader: FSM states,
// butterfly pair/twiddle index functions and the per-pair metadata record.
package ntt_pkg;

  localparam int MAX_LOGN = 16;

  typedef logic [MAX_LOGN-1:0] idx_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_WB,
    ST_DONE
  } state_t;

  typedef struct packed {
    idx_t       a;
    idx_t       b;
    logic [3:0] stage;
    logic       last;
  } meta_t;

  // a = ((p >> s) << (s+1)) | (p mod 2^s)
  function automatic idx_t pair_a(input idx_t p, input logic [3:0] s);
    idx_t half_mask;
    half_mask = (idx_t'(1) << s) - idx_t'(1);
    return (((p >> s) << s) << 1) | (p & half_mask);
  endfunction

  function automatic idx_t pair_b(input idx_t p, input logic [3:0] s);
    return pair_a(p, s) + (idx_t'(1) << s);
  endfunction

  function automatic idx_t tw_idx(input idx_t p, input logic [3:0] s, input logic [4:0] logn);
    idx_t half_mask;
    half_mask = (idx_t'(1) << s) - idx_t'(1);
    return (p & half_mask) << (logn - 5'd1 - {1'b0, s});
  endfunction

endpackage

// File: rtl/ntt_pair_fifo.sv
// Small synchronous FIFO with occupancy count; head is presented
// combinationally so a push is visible on the output the following cycle.
module ntt_pair_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic [CW-1:0] count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ntt_stage_reader.sv
// In-place Cooley-Tukey schedule generator: issues butterfly reads per stage,
// buffers returned operands with their write-back metadata, and waits for the
// writer between stages.
module ntt_stage_reader
  import ntt_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int LOGN       = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [WIDTH-1:0] W1_CONST = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [LOGN-1:0]          rd_addr_1,
  output logic [LOGN-1:0]          rd_addr_2,
  output logic [LOGN-2:0]          tw_addr,
  input  logic [WIDTH-1:0]         rd_data_1,
  input  logic [WIDTH-1:0]         rd_data_2,
  input  logic [WIDTH-1:0]         tw_rd_data,
  output logic [WIDTH-1:0]         input_1,
  output logic [WIDTH-1:0]         input_2,
  output logic [WIDTH-1:0]         weight_1,
  output logic [WIDTH-1:0]         weight_2,
  output logic [LOGN-1:0]          out_addr_1,
  output logic [LOGN-1:0]          out_addr_2,
  output logic [$clog2(LOGN)-1:0]  out_stage,
  output logic                     out_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  input  logic                     wb_done
);

  localparam int SW = $clog2(LOGN);
  localparam int PW = LOGN - 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = 3 * WIDTH + 2 * LOGN + SW + 1;
  localparam logic [PW-1:0] P_LAST = {PW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);

  state_t        state_q;
  logic [SW-1:0] s_q;
  logic [PW-1:0] p_q;
  logic          inflight_q;
  meta_t         meta_q;

  idx_t          a_full;
  idx_t          b_full;
  idx_t          tw_full;
  logic          rd_go;
  logic          last_pair;
  logic [CW-1:0] fifo_count;
  logic          pop;
  logic [EW-1:0] push_data;
  logic [EW-1:0] head_data;
  logic          unused_bits;

  assign a_full    = pair_a(idx_t'(p_q), 4'(s_q));
  assign b_full    = pair_b(idx_t'(p_q), 4'(s_q));
  assign tw_full   = tw_idx(idx_t'(p_q), 4'(s_q), 5'(LOGN));
  assign last_pair = (p_q == P_LAST);

  // Credit: buffered entries plus the read still in flight must leave room.
  assign rd_go = (state_q == ST_ISSUE) &&
                 (({1'b0, fifo_count} + (CW+1)'(inflight_q)) < (CW+1)'(FIFO_DEPTH));

  assign rd_en     = rd_go;
  assign rd_addr_1 = rd_go ? a_full[LOGN-1:0]  : '0;
  assign rd_addr_2 = rd_go ? b_full[LOGN-1:0]  : '0;
  assign tw_addr   = rd_go ? tw_full[LOGN-2:0] : '0;

  assign busy = (state_q == ST_ISSUE) || (state_q == ST_WAIT_WB);
  assign done = (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      p_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ISSUE;
            s_q     <= '0;
            p_q     <= '0;
          end
        end
        ST_ISSUE: begin
          if (rd_go) begin
            p_q <= p_q + 1'b1;
            if (last_pair) state_q <= ST_WAIT_WB;
          end
        end
        ST_WAIT_WB: begin
          if (wb_done) begin
            if (s_q == S_LAST) begin
              state_q <= ST_DONE;
            end else begin
              s_q     <= s_q + 1'b1;
              p_q     <= '0;
              state_q <= ST_ISSUE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Metadata rides one cycle behind rd_en so it lines up with the RAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      meta_q     <= '0;
    end else begin
      inflight_q <= rd_go;
      if (rd_go) begin
        meta_q <= '{a: a_full, b: b_full, stage: 4'(s_q), last: last_pair};
      end
    end
  end

  assign push_data = {rd_data_1, rd_data_2, tw_rd_data,
                      meta_q.a[LOGN-1:0], meta_q.b[LOGN-1:0],
                      meta_q.stage[SW-1:0], meta_q.last};

  ntt_pair_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .count_o (fifo_count)
  );

  logic [WIDTH-1:0] h_in1, h_in2, h_tw;
  logic [LOGN-1:0]  h_a, h_b;
  logic [SW-1:0]    h_s;
  logic             h_last;

  assign {h_in1, h_in2, h_tw, h_a, h_b, h_s, h_last} = head_data;

  assign out_valid  = (fifo_count != '0);
  assign pop        = out_valid & out_ready;
  assign input_1    = out_valid ? h_in1    : '0;
  assign input_2    = out_valid ? h_in2    : '0;
  assign weight_2   = out_valid ? h_tw     : '0;
  assign weight_1   = out_valid ? W1_CONST : '0;
  assign out_addr_1 = out_valid ? h_a      : '0;
  assign out_addr_2 = out_valid ? h_b      : '0;
  assign out_stage  = out_valid ? h_s      : '0;
  assign out_last   = out_valid & h_last;

  assign unused_bits = ^{meta_q, a_full, b_full, tw_full};

endmodule

// File: tb/tb_ntt_stage_reader.sv
// Self-checking bench for ntt_stage_reader at LOGN=3 with a 3-entry buffer:
// table of expected pairs feeds a scoreboard queue checked on each handshake.
module tb_ntt_stage_reader;

  localparam int WIDTH = 18;
  localparam int LOGN  = 3;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             busy, done, rd_en;
  logic [LOGN-1:0]  rd_addr_1, rd_addr_2;
  logic [LOGN-2:0]  tw_addr;
  logic [WIDTH-1:0] rd_data_1 = '0, rd_data_2 = '0, tw_rd_data = '0;
  logic [WIDTH-1:0] input_1, input_2, weight_1, weight_2;
  logic [LOGN-1:0]  out_addr_1, out_addr_2;
  logic [1:0]       out_stage;
  logic             out_last, out_valid;
  logic             out_ready = 1'b1;
  logic             wb_done = 1'b0;

  ntt_stage_reader #(
    .WIDTH(WIDTH), .LOGN(LOGN), .FIFO_DEPTH(DEPTH), .W1_CONST(18'd1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2), .tw_addr(tw_addr),
    .rd_data_1(rd_data_1), .rd_data_2(rd_data_2), .tw_rd_data(tw_rd_data),
    .input_1(input_1), .input_2(input_2), .weight_1(weight_1), .weight_2(weight_2),
    .out_addr_1(out_addr_1), .out_addr_2(out_addr_2), .out_stage(out_stage),
    .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  // RAM returns addr+100, ROM returns addr+50, one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data_1  <= 18'(rd_addr_1) + 18'd100;
      rd_data_2  <= 18'(rd_addr_2) + 18'd100;
      tw_rd_data <= 18'(tw_addr) + 18'd50;
    end
  end

  typedef struct {
    int a;
    int b;
    int tw;
    int stage;
    int last;
  } exp_t;

  exp_t vec[12];
  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   rd_total = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, expv);
    end
  endtask

  // Scoreboard: every handshake must match the oldest expected pair.
  always @(negedge clk) begin
    if (rd_en) rd_total++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pair got a=%0d b=%0d s=%0d exp none", out_addr_1, out_addr_2, out_stage);
      end else begin
        e = exp_q.pop_front();
        $display("PAIR s=%0d a=%0d b=%0d tw=%0d last=%0d in1=%0d in2=%0d w2=%0d",
                 out_stage, out_addr_1, out_addr_2, int'(weight_2) - 50, out_last,
                 input_1, input_2, weight_2);
        chk("out_addr_1", int'(out_addr_1), e.a);
        chk("out_addr_2", int'(out_addr_2), e.b);
        chk("input_1",    int'(input_1),    e.a + 100);
        chk("input_2",    int'(input_2),    e.b + 100);
        chk("weight_2",   int'(weight_2),   e.tw + 50);
        chk("weight_1",   int'(weight_1),   1);
        chk("out_stage",  int'(out_stage),  e.stage);
        chk("out_last",   int'(out_last),   e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  task automatic push_stage(input int s);
    for (int i = s * 4; i < s * 4 + 4; i++) exp_q.push_back(vec[i]);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      cyc();
      n++;
    end
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic pulse_wb(input int next_stage);
    wb_done = 1'b1;
    if (next_stage >= 0) push_stage(next_stage);
    cyc();
    wb_done = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    push_stage(0);
    cyc();
    start = 1'b0;
  endtask

  initial begin
    vec[0]  = '{0, 1, 0, 0, 0};
    vec[1]  = '{2, 3, 0, 0, 0};
    vec[2]  = '{4, 5, 0, 0, 0};
    vec[3]  = '{6, 7, 0, 0, 1};
    vec[4]  = '{0, 2, 0, 1, 0};
    vec[5]  = '{1, 3, 2, 1, 0};
    vec[6]  = '{4, 6, 0, 1, 0};
    vec[7]  = '{5, 7, 2, 1, 1};
    vec[8]  = '{0, 4, 0, 2, 0};
    vec[9]  = '{1, 5, 1, 2, 0};
    vec[10] = '{2, 6, 2, 2, 0};
    vec[11] = '{3, 7, 3, 2, 1};

    // Reset state
    repeat (3) cyc();
    rst = 1'b0;
    cyc();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_rd_addr_2", int'(rd_addr_2), 0);
    chk("rst_weight_1", int'(weight_1), 0);

    // Full transform, out_ready high, with start latency and done timing
    pulse_start();
    chk("lat_busy", int'(busy), 1);
    chk("lat_rd_en", int'(rd_en), 1);
    chk("lat_rd_addr_2", int'(rd_addr_2), 1);
    chk("lat_valid_t1", int'(out_valid), 0);
    cyc();
    chk("lat_valid_t2", int'(out_valid), 0);
    cyc();
    chk("lat_valid_t3", int'(out_valid), 1);
    wait_drain("stage0");
    pulse_wb(1);
    // wb_done and start during ISSUE must be ignored
    wb_done = 1'b1;
    start = 1'b1;
    cyc();
    wb_done = 1'b0;
    start = 1'b0;
    chk("ign_busy", int'(busy), 1);
    wait_drain("stage1");
    pulse_wb(2);
    wait_drain("stage2");
    chk("pre_done", int'(done), 0);
    pulse_wb(-1);
    chk("done_pulse", int'(done), 1);
    chk("done_busy", int'(busy), 0);
    cyc();
    chk("done_clear", int'(done), 0);
    chk("idle_busy", int'(busy), 0);

    // Back-pressure: reads stop once the buffer plus in-flight read is full
    out_ready = 1'b0;
    rd_total = 0;
    pulse_start();
    repeat (10) cyc();
    chk("stall_reads", rd_total, DEPTH);
    chk("stall_rd_en", int'(rd_en), 0);
    chk("stall_valid", int'(out_valid), 1);
    chk("stall_head", int'(input_1), 100);
    out_ready = 1'b1;
    wait_drain("stall");
    repeat (3) cyc();
    chk("stall_total", rd_total, 4);
    chk("stall_empty", int'(out_valid), 0);

    // Reset in the middle of stage 1, then a fresh stage 0
    pulse_wb(1);
    begin
      int n;
      n = 0;
      while (exp_q.size() > 3 && n < 20) begin
        cyc();
        n++;
      end
      chk("mid1_started", (exp_q.size() <= 3) ? 1 : 0, 1);
    end
    out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    cyc();
    rst = 1'b0;
    chk("mrst_valid", int'(out_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_rd_en", int'(rd_en), 0);
    out_ready = 1'b1;
    repeat (5) cyc();
    chk("mrst_quiet", int'(out_valid), 0);
    pulse_start();
    wait_drain("restart");
    chk("restart_busy", int'(busy), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
